// File: rtl/nodf_mon_pkg.sv
// Shared types and helpers for the non-dataflow HLS block status tracker.
// Holds the tracker state encoding, proto_err bit positions and a saturating increment.
// Used by nodf_sat_counter and nodf_module_status_tracker via import nodf_mon_pkg::*.
package nodf_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_BUSY      = 2'b01,
    ST_DONE_WAIT = 2'b10
  } state_e;

  // proto_err bit positions
  localparam int PE_CMPL_IDLE  = 0;  // completion with nothing outstanding
  localparam int PE_START_DROP = 1;  // ap_start withdrawn before acceptance
  localparam int PE_OUT_SAT    = 2;  // outstanding counter clamped at max

  // Increment v unless it already sits at the all-ones value of a w-bit field.
  // Callers zero-extend into 64 bits and truncate the result back to w bits.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/nodf_sat_counter.sv
// Saturating up-counter with synchronous clear and hold; never wraps.
// Ports: i_clock, i_reset (sync, active-high), i_clr (sync clear), i_hold (freeze), i_inc, o_cnt.
// Latency: o_cnt reflects an increment one clock after i_inc is sampled.
module nodf_sat_counter
  import nodf_mon_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_hold,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (!i_hold && i_inc) begin
      r_cnt <= W'(sat_inc(64'(r_cnt), W));
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/nodf_module_status_tracker.sv
// Status tracker for one ap_ctrl_hs/chain HLS block: transaction, busy/stall counts,
// outstanding work and start-to-done latency; everything freezes once i_finish is seen.
// Ports: i_clock, i_reset (sync, active-high), i_ap_start/ready/done/continue, i_finish;
//        o_state, o_*_cnt, o_outstanding, o_last/min/max_lat, o_finished, o_proto_err.
// All outputs are registered (one cycle after the sampling edge).
// Macro NODF_PROTO_CHECK_EN builds sticky protocol checks; otherwise o_proto_err is 3'b000.
module nodf_module_status_tracker
  import nodf_mon_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int OUT_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_ap_start,
  input  logic             i_ap_ready,
  input  logic             i_ap_done,
  input  logic             i_ap_continue,
  input  logic             i_finish,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_cyc_cnt,
  output logic [CNT_W-1:0] o_start_cnt,
  output logic [CNT_W-1:0] o_ready_cnt,
  output logic [CNT_W-1:0] o_done_cnt,
  output logic [CNT_W-1:0] o_busy_cnt,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [OUT_W-1:0] o_outstanding,
  output logic [CNT_W-1:0] o_last_lat,
  output logic [CNT_W-1:0] o_min_lat,
  output logic [CNT_W-1:0] o_max_lat,
  output logic             o_finished,
  output logic [2:0]       o_proto_err
);

  state_e           r_state, w_state_n;
  logic [OUT_W-1:0] r_out, w_out_n;
  logic [CNT_W-1:0] r_timer, r_last, r_min, r_max, w_lat_now;
  logic             r_finished;
  logic             w_acc, w_cmpl, w_hold, w_out_zero, w_out_max;

  assign w_acc      = i_ap_start & i_ap_ready;
  assign w_cmpl     = i_ap_done & i_ap_continue;
  // The edge that samples i_finish is already a frozen edge.
  assign w_hold     = r_finished | i_finish;
  assign w_out_zero = (r_out == '0);
  assign w_out_max  = (r_out == {OUT_W{1'b1}});
  // Acceptance cycle counts as 0; with nothing outstanding the timer is meaningless.
  assign w_lat_now  = w_out_zero ? '0 : r_timer;

  // Next outstanding count, clamped to [0, max]; acc and cmpl together cancel.
  always_comb begin
    w_out_n = r_out;
    if (w_acc && !w_cmpl && !w_out_max) begin
      w_out_n = r_out + 1'b1;
    end else if (!w_acc && w_cmpl && !w_out_zero) begin
      w_out_n = r_out - 1'b1;
    end
  end

  always_comb begin
    w_state_n = ST_IDLE;
    if (i_ap_done && !i_ap_continue) begin
      w_state_n = ST_DONE_WAIT;
    end else if ((w_out_n != '0) || (i_ap_start && !w_acc)) begin
      w_state_n = ST_BUSY;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_out      <= '0;
      r_timer    <= '0;
      r_last     <= '0;
      r_min      <= '1;
      r_max      <= '0;
      r_finished <= 1'b0;
    end else if (r_finished) begin
      // frozen until reset
    end else if (i_finish) begin
      r_finished <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_out   <= w_out_n;
      // Timer holds cycles elapsed since the arming acceptance; it is rearmed only
      // when the block was empty, so overlapping transactions share one time base.
      if (w_out_zero) begin
        r_timer <= w_acc ? CNT_W'(1) : '0;
      end else begin
        r_timer <= CNT_W'(sat_inc(64'(r_timer), CNT_W));
      end
      if (w_cmpl) begin
        r_last <= w_lat_now;
        if (w_lat_now < r_min) r_min <= w_lat_now;
        if (w_lat_now > r_max) r_max <= w_lat_now;
      end
    end
  end

  nodf_sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .i_clock(i_clock), .i_reset(i_reset), .i_clr(1'b0), .i_hold(w_hold),
    .i_inc(1'b1), .o_cnt(o_cyc_cnt));
  nodf_sat_counter #(.W(CNT_W)) u_start_cnt (
    .i_clock(i_clock), .i_reset(i_reset), .i_clr(1'b0), .i_hold(w_hold),
    .i_inc(w_acc), .o_cnt(o_start_cnt));
  nodf_sat_counter #(.W(CNT_W)) u_ready_cnt (
    .i_clock(i_clock), .i_reset(i_reset), .i_clr(1'b0), .i_hold(w_hold),
    .i_inc(i_ap_ready), .o_cnt(o_ready_cnt));
  nodf_sat_counter #(.W(CNT_W)) u_done_cnt (
    .i_clock(i_clock), .i_reset(i_reset), .i_clr(1'b0), .i_hold(w_hold),
    .i_inc(w_cmpl), .o_cnt(o_done_cnt));
  nodf_sat_counter #(.W(CNT_W)) u_busy_cnt (
    .i_clock(i_clock), .i_reset(i_reset), .i_clr(1'b0), .i_hold(w_hold),
    .i_inc(r_state != ST_IDLE), .o_cnt(o_busy_cnt));
  nodf_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clock(i_clock), .i_reset(i_reset), .i_clr(1'b0), .i_hold(w_hold),
    .i_inc(i_ap_done & ~i_ap_continue), .o_cnt(o_stall_cnt));

`ifdef NODF_PROTO_CHECK_EN
  logic       r_pend;  // ap_start was high but not accepted last cycle
  logic [2:0] r_perr;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pend <= 1'b0;
      r_perr <= 3'b000;
    end else if (!w_hold) begin
      r_pend <= i_ap_start & ~w_acc;
      if (w_cmpl && w_out_zero && !w_acc)
        r_perr[PE_CMPL_IDLE] <= 1'b1;
      if (r_pend && !i_ap_start && (r_state == ST_BUSY) && w_out_zero)
        r_perr[PE_START_DROP] <= 1'b1;
      if (w_acc && !w_cmpl && w_out_max)
        r_perr[PE_OUT_SAT] <= 1'b1;
    end
  end

  assign o_proto_err = r_perr;
`else
  assign o_proto_err = 3'b000;
`endif

  assign o_state       = r_state;
  assign o_outstanding = r_out;
  assign o_last_lat    = r_last;
  assign o_min_lat     = r_min;
  assign o_max_lat     = r_max;
  assign o_finished    = r_finished;

endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Self-checking bench for nodf_module_status_tracker: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
// Build with NODF_PROTO_CHECK_EN defined to exercise the protocol-error bits.
module tb_nodf_module_status_tracker;

  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;
  localparam int     OMAX = 255;

  logic clk = 1'b0;
  logic rst, st, rd, dn, ct, fin;

  logic [1:0]  o_state;
  logic [31:0] o_cyc_cnt, o_start_cnt, o_ready_cnt, o_done_cnt, o_busy_cnt, o_stall_cnt;
  logic [7:0]  o_outstanding;
  logic [31:0] o_last_lat, o_min_lat, o_max_lat;
  logic        o_finished;
  logic [2:0]  o_proto_err;

  always #5 clk = ~clk;

  nodf_module_status_tracker #(.CNT_W(32), .OUT_W(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_ap_start(st), .i_ap_ready(rd),
    .i_ap_done(dn), .i_ap_continue(ct), .i_finish(fin),
    .o_state(o_state), .o_cyc_cnt(o_cyc_cnt), .o_start_cnt(o_start_cnt),
    .o_ready_cnt(o_ready_cnt), .o_done_cnt(o_done_cnt), .o_busy_cnt(o_busy_cnt),
    .o_stall_cnt(o_stall_cnt), .o_outstanding(o_outstanding), .o_last_lat(o_last_lat),
    .o_min_lat(o_min_lat), .o_max_lat(o_max_lat), .o_finished(o_finished),
    .o_proto_err(o_proto_err));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // Transactions are tracked as counts plus the time of the acceptance that
  // opened the current busy period; latency is simply elapsed time since then.
  longint m_t;
  longint m_cyc, m_start, m_ready, m_done, m_busy, m_stall, m_last, m_min, m_max, m_arm;
  int     m_out, m_state;
  bit     m_fin, m_pend;
  bit [2:0] m_perr;

  function automatic longint sat1(input longint v, input bit inc);
    return (inc && v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_tick(input bit r, input bit s, input bit y, input bit d,
                            input bit c, input bit f);
    bit acc, cmpl;
    longint lat;
    int out_n;
    m_t++;
    if (r) begin
      m_cyc = 0; m_start = 0; m_ready = 0; m_done = 0; m_busy = 0; m_stall = 0;
      m_last = 0; m_min = CMAX; m_max = 0; m_out = 0; m_state = 0;
      m_fin = 0; m_pend = 0; m_perr = 3'b000; m_arm = 0;
      return;
    end
    if (m_fin) return;
    if (f) begin
      m_fin = 1;
      return;
    end
    acc  = s & y;
    cmpl = d & c;
    lat  = (m_out == 0) ? 0 : ((m_t - 1 - m_arm) > CMAX ? CMAX : (m_t - 1 - m_arm));
    if (cmpl && m_out == 0 && !acc) m_perr[0] = 1;
    if (m_pend && !s && m_state == 1 && m_out == 0) m_perr[1] = 1;
    if (acc && !cmpl && m_out == OMAX) m_perr[2] = 1;
    m_pend  = s & !acc;
    m_cyc   = sat1(m_cyc, 1);
    m_start = sat1(m_start, acc);
    m_ready = sat1(m_ready, y);
    m_done  = sat1(m_done, cmpl);
    m_busy  = sat1(m_busy, m_state != 0);
    m_stall = sat1(m_stall, d & !c);
    if (cmpl) begin
      m_last = lat;
      if (lat < m_min) m_min = lat;
      if (lat > m_max) m_max = lat;
    end
    if (acc && m_out == 0) m_arm = m_t - 1;
    out_n = m_out + int'(acc) - int'(cmpl);
    if (out_n < 0) out_n = 0;
    if (out_n > OMAX) out_n = OMAX;
    if (d && !c) m_state = 2;
    else if (out_n > 0 || (s && !acc)) m_state = 1;
    else m_state = 0;
    m_out = out_n;
  endtask

  task automatic check_all();
    bit [2:0] exp_perr;
`ifdef NODF_PROTO_CHECK_EN
    exp_perr = m_perr;
`else
    exp_perr = 3'b000;
`endif
    chk("state",       64'(o_state),       64'(m_state));
    chk("cyc_cnt",     64'(o_cyc_cnt),     64'(m_cyc));
    chk("start_cnt",   64'(o_start_cnt),   64'(m_start));
    chk("ready_cnt",   64'(o_ready_cnt),   64'(m_ready));
    chk("done_cnt",    64'(o_done_cnt),    64'(m_done));
    chk("busy_cnt",    64'(o_busy_cnt),    64'(m_busy));
    chk("stall_cnt",   64'(o_stall_cnt),   64'(m_stall));
    chk("outstanding", 64'(o_outstanding), 64'(m_out));
    chk("last_lat",    64'(o_last_lat),    64'(m_last));
    chk("min_lat",     64'(o_min_lat),     64'(m_min));
    chk("max_lat",     64'(o_max_lat),     64'(m_max));
    chk("finished",    64'(o_finished),    64'(m_fin));
    chk("proto_err",   64'(o_proto_err),   64'(exp_perr));
  endtask

  // Drive one cycle of inputs, let the edge sample them, then compare away from the edge.
  task automatic step(input bit s, input bit y, input bit d, input bit c, input bit f);
    st = s; rd = y; dn = d; ct = c; fin = f;
    @(posedge clk);
    #1;
    model_tick(rst, s, y, d, c, f);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 1);  // finish during reset must be ignored
    step(1, 1, 1, 1, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; st = 0; rd = 0; dn = 0; ct = 0; fin = 0;
    m_t = 0;
    do_reset();
    chk("rst_min_lat",  64'(o_min_lat), 64'hFFFF_FFFF);
    chk("rst_finished", 64'(o_finished), 0);

    // single transaction: acc at 0, cmpl at 5
    for (int i = 0; i <= 5; i++) step(i == 0, i == 0, i == 5, 1, 0);
    chk("single_start", 64'(o_start_cnt), 1);
    chk("single_done",  64'(o_done_cnt), 1);
    chk("single_last",  64'(o_last_lat), 5);
    chk("single_min",   64'(o_min_lat), 5);
    chk("single_max",   64'(o_max_lat), 5);
    chk("single_busy",  64'(o_busy_cnt), 5);
    chk("single_idle",  64'(o_state), 0);

    // pipelined: acc at 0,2,4; cmpl at 6,8,10
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      step(i == 0 || i == 2 || i == 4, 1, i == 6 || i == 8 || i == 10, 1, 0);
      if (i == 4) chk("pipe_peak", 64'(o_outstanding), 3);
    end
    chk("pipe_done", 64'(o_done_cnt), 3);
    chk("pipe_max",  64'(o_max_lat), 10);
    chk("pipe_min",  64'(o_min_lat), 6);
    chk("pipe_out",  64'(o_outstanding), 0);

    // back-pressure: done held 4 cycles without continue
    do_reset();
    step(1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0);
      chk("bp_donewait", 64'(o_state), 2);
    end
    step(0, 0, 1, 1, 0);
    chk("bp_stall", 64'(o_stall_cnt), 4);
    chk("bp_done",  64'(o_done_cnt), 1);
    chk("bp_idle",  64'(o_state), 0);

    // ready-only tap
    do_reset();
    for (int i = 0; i < 6; i++) step(0, i[0], 0, 0, 0);
    chk("tap_ready", 64'(o_ready_cnt), 3);
    chk("tap_start", 64'(o_start_cnt), 0);
    chk("tap_state", 64'(o_state), 0);

    // zero-latency and protocol error: cmpl with nothing outstanding
    do_reset();
    step(1, 1, 1, 1, 0);
    chk("zlat_last", 64'(o_last_lat), 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
`ifdef NODF_PROTO_CHECK_EN
    chk("perr_cmpl_idle", 64'(o_proto_err), 1);
`else
    chk("perr_tied_zero", 64'(o_proto_err), 0);
`endif

    // outstanding saturation
    do_reset();
    for (int i = 0; i < 260; i++) step(1, 1, 0, 1, 0);
    chk("out_sat", 64'(o_outstanding), 255);

    // randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bit s, y, d, c;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        s = ($urandom_range(0, 2) == 0);
        y = $urandom_range(0, 1) == 1;
        d = (m_out > 0 || (s && y)) && ($urandom_range(0, 2) == 0);
        c = ($urandom_range(0, 3) != 0);
        step(s, y, d, c, 0);
      end
    end

    // finish freeze after two transactions
    do_reset();
    step(1, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(1, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0);
    chk("fin_finished", 64'(o_finished), 1);
    chk("fin_done",     64'(o_done_cnt), 2);
    chk("fin_start",    64'(o_start_cnt), 2);
    chk("fin_cyc",      64'(o_cyc_cnt), 5);
    chk("fin_state",    64'(o_state), 0);
    do_reset();
    chk("fin_rst_finished", 64'(o_finished), 0);
    chk("fin_rst_done",     64'(o_done_cnt), 0);
    chk("fin_rst_cyc",      64'(o_cyc_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
